// File: rtl/psum_out_sched_if.sv
// Channel-side and packer-side signals of the psum output scheduler.
// master = scheduler, slave = PE array / packer environment.
interface psum_out_sched_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0] ch_valid;
    logic [NUM_CH-1:0] ch_data;
    logic [NUM_CH-1:0] ch_ready;
    logic              pk_valid;
    logic              pk_data;
    logic              pk_layer_finish;
    logic [1:0]        pk_operation;

    modport master (
        input  ch_valid, ch_data,
        output ch_ready, pk_valid, pk_data, pk_layer_finish, pk_operation
    );

    modport slave (
        output ch_valid, ch_data,
        input  ch_ready, pk_valid, pk_data, pk_layer_finish, pk_operation
    );
endinterface

// File: rtl/psum_out_sched.sv
// Round-robin bit scheduler from NUM_CH PE result channels into the 1-bit psum packer,
// with per-layer bit counting and a layer-finish pulse that never overlaps pk_valid.
module psum_out_sched #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_start,
    input  logic [1:0]           cfg_operation,
    input  logic [CNT_W-1:0]     cfg_total_bits,
    psum_out_sched_if.master     bus,
    output logic                 busy,
    output logic                 done
);
    localparam int             PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [PTR_W:0] NCH   = (PTR_W+1)'(NUM_CH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [PTR_W-1:0] rr_q, rr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] total_q, total_d;
    logic [1:0]       op_q, op_d;
    logic             pkv_q, pkv_d;
    logic             pkd_q, pkd_d;
    logic             fin_q, fin_d;
    logic             done_q, done_d;

    logic              found;
    logic [PTR_W-1:0]  gidx;
    logic [PTR_W:0]    idx;
    logic [PTR_W:0]    gnext;
    logic [NUM_CH-1:0] ready_c;
    logic              xfer;

    // Search from rr_q upward, wrapping modulo NUM_CH; idx is one bit wider so the
    // sum never overflows before the wrap subtraction.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = {1'b0, rr_q} + (PTR_W+1)'(i);
            if (idx >= NCH) idx = idx - NCH;
            if (!found && bus.ch_valid[idx[PTR_W-1:0]]) begin
                found = 1'b1;
                gidx  = idx[PTR_W-1:0];
            end
        end
    end

    assign xfer  = (state_q == S_RUN) && found;
    assign gnext = ({1'b0, gidx} + 1'b1 == NCH) ? '0 : {1'b0, gidx} + 1'b1;

    always_comb begin
        ready_c = '0;
        if (xfer) ready_c[gidx] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        total_d = total_q;
        op_d    = op_q;
        pkv_d   = 1'b0;
        pkd_d   = pkd_q;
        fin_d   = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    total_d = cfg_total_bits;
                    op_d    = cfg_operation;
                    cnt_d   = '0;
                    rr_d    = '0;
                    state_d = (cfg_total_bits != '0) ? S_RUN : S_FLUSH;
                end
            end
            S_RUN: begin
                if (xfer) begin
                    pkv_d = 1'b1;
                    pkd_d = bus.ch_data[gidx];
                    cnt_d = cnt_q + CNT_W'(1);
                    rr_d  = gnext[PTR_W-1:0];
                    if (cnt_q == total_q - CNT_W'(1)) state_d = S_FLUSH;
                end
            end
            // FLUSH is the cycle carrying the final pk_valid; finish follows it.
            S_FLUSH: begin
                fin_d   = 1'b1;
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            cnt_q   <= '0;
            total_q <= '0;
            op_q    <= '0;
            pkv_q   <= 1'b0;
            pkd_q   <= 1'b0;
            fin_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            total_q <= total_d;
            op_q    <= op_d;
            pkv_q   <= pkv_d;
            pkd_q   <= pkd_d;
            fin_q   <= fin_d;
            done_q  <= done_d;
        end
    end

    assign bus.ch_ready        = ready_c;
    assign bus.pk_valid        = pkv_q;
    assign bus.pk_data         = pkd_q;
    assign bus.pk_layer_finish = fin_q;
    assign bus.pk_operation    = op_q;
    assign busy                = (state_q != S_IDLE);
    assign done                = done_q;
endmodule

// File: tb/tb_psum_out_sched.sv
// Directed bench for psum_out_sched: single channel, round-robin, sparse, zero-length,
// ignored start and mid-layer reset, with hand-computed expectations.
module tb_psum_out_sched;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_start;
    logic [1:0]  cfg_operation;
    logic [15:0] cfg_total_bits;
    logic        busy, done;
    int          nchk = 0;
    int          nerr = 0;

    psum_out_sched_if #(.NUM_CH(4)) bus ();

    psum_out_sched #(.NUM_CH(4), .CNT_W(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_start      (cfg_start),
        .cfg_operation  (cfg_operation),
        .cfg_total_bits (cfg_total_bits),
        .bus            (bus),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [15:0] tot, input logic [1:0] op);
        cfg_start      = 1'b1;
        cfg_total_bits = tot;
        cfg_operation  = op;
        step();
        cfg_start = 1'b0;
    endtask

    // Runs up to maxc cycles counting emitted bits and finish pulses; optionally injects
    // a second start (total 9, op 1) at cycle inj.
    task automatic run_count(input int maxc, input int inj,
                             output int nbits, output int nfin, output int novl);
        nbits = 0; nfin = 0; novl = 0;
        for (int c = 0; c < maxc; c++) begin
            if (c == inj) begin
                cfg_start = 1'b1; cfg_total_bits = 16'd9; cfg_operation = 2'd1;
            end else begin
                cfg_start = 1'b0;
            end
            step();
            if (bus.pk_valid) nbits++;
            if (bus.pk_layer_finish) nfin++;
            if (bus.pk_valid && bus.pk_layer_finish) novl++;
        end
        cfg_start = 1'b0;
    endtask

    logic [4:0] d1;
    logic [3:0] sp_v [5];
    logic [3:0] sp_r [5];
    logic [4:0] sp_pv;
    int nb, nf, no;

    initial begin
        rst_n = 1'b0; cfg_start = 1'b0; cfg_operation = 2'd0; cfg_total_bits = '0;
        bus.ch_valid = '0; bus.ch_data = '0;
        #12;
        chk("rst_pkv",  {31'd0, bus.pk_valid}, 0);
        chk("rst_fin",  {31'd0, bus.pk_layer_finish}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_op",   {30'd0, bus.pk_operation}, 0);
        rst_n = 1'b1;
        step();

        // Single channel, total 5, data 1,0,1,1,0
        d1 = 5'b01101;
        start(16'd5, 2'd3);
        chk("t1_busy", {31'd0, busy}, 1);
        bus.ch_valid = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            bus.ch_data = {3'b000, d1[k]};
            #1 chk("t1_rdy", {28'd0, bus.ch_ready}, 32'h1);
            step();
            chk("t1_pkv", {31'd0, bus.pk_valid}, 1);
            chk("t1_pkd", {31'd0, bus.pk_data}, {31'd0, d1[k]});
            chk("t1_fin_lo", {31'd0, bus.pk_layer_finish}, 0);
        end
        #1 chk("t1_rdy_flush", {28'd0, bus.ch_ready}, 0);
        step();
        chk("t1_fin",  {31'd0, bus.pk_layer_finish}, 1);
        chk("t1_done", {31'd0, done}, 1);
        chk("t1_pkv_lo", {31'd0, bus.pk_valid}, 0);
        chk("t1_op",   {30'd0, bus.pk_operation}, 3);
        step();
        chk("t1_fin_drop", {31'd0, bus.pk_layer_finish}, 0);
        chk("t1_busy_lo",  {31'd0, busy}, 0);
        bus.ch_valid = '0;

        // Round-robin with all four channels valid, total 8
        start(16'd8, 2'd1);
        bus.ch_valid = 4'b1111;
        bus.ch_data  = 4'b1010;
        for (int k = 0; k < 8; k++) begin
            #1 chk("t2_rdy", {28'd0, bus.ch_ready}, 32'h1 << (k % 4));
            step();
            chk("t2_pkv", {31'd0, bus.pk_valid}, 1);
            chk("t2_pkd", {31'd0, bus.pk_data}, ((k % 2) == 1) ? 32'd1 : 32'd0);
        end
        #1 chk("t2_rdy_flush", {28'd0, bus.ch_ready}, 0);
        step();
        chk("t2_fin", {31'd0, bus.pk_layer_finish}, 1);
        chk("t2_rdy_done", {28'd0, bus.ch_ready}, 0);
        step();
        chk("t2_rdy_idle", {28'd0, bus.ch_ready}, 0);
        chk("t2_busy_lo", {31'd0, busy}, 0);
        bus.ch_valid = '0;

        // Sparse requesters, total 3; rr_ptr wraps after ch3
        sp_v[0] = 4'b0000; sp_v[1] = 4'b0100; sp_v[2] = 4'b0000; sp_v[3] = 4'b1010; sp_v[4] = 4'b1010;
        sp_r[0] = 4'b0000; sp_r[1] = 4'b0100; sp_r[2] = 4'b0000; sp_r[3] = 4'b1000; sp_r[4] = 4'b0010;
        sp_pv = 5'b11010;
        bus.ch_data = 4'b0110;
        start(16'd3, 2'd2);
        for (int k = 0; k < 5; k++) begin
            bus.ch_valid = sp_v[k];
            #1 chk("t3_rdy", {28'd0, bus.ch_ready}, {28'd0, sp_r[k]});
            step();
            chk("t3_pkv", {31'd0, bus.pk_valid}, {31'd0, sp_pv[k]});
            if (k == 2) chk("t3_hold", {31'd0, bus.pk_data}, 1);
            if (k == 3) chk("t3_pkd_ch3", {31'd0, bus.pk_data}, 0);
            if (k == 4) chk("t3_pkd_ch1", {31'd0, bus.pk_data}, 1);
        end
        step();
        chk("t3_fin", {31'd0, bus.pk_layer_finish}, 1);
        step();
        bus.ch_valid = '0;

        // Zero-length layer
        bus.ch_valid = 4'b1111;
        start(16'd0, 2'd0);
        #1 chk("t4_rdy", {28'd0, bus.ch_ready}, 0);
        chk("t4_pkv", {31'd0, bus.pk_valid}, 0);
        chk("t4_busy", {31'd0, busy}, 1);
        step();
        chk("t4_fin", {31'd0, bus.pk_layer_finish}, 1);
        chk("t4_pkv2", {31'd0, bus.pk_valid}, 0);
        chk("t4_op", {30'd0, bus.pk_operation}, 0);
        step();
        chk("t4_fin_drop", {31'd0, bus.pk_layer_finish}, 0);
        bus.ch_valid = '0;

        // Start while busy is ignored
        bus.ch_valid = 4'b0001; bus.ch_data = 4'b0001;
        start(16'd4, 2'd3);
        run_count(12, 1, nb, nf, no);
        chk("t5_bits", nb, 4);
        chk("t5_fins", nf, 1);
        chk("t5_ovl", no, 0);
        chk("t5_op", {30'd0, bus.pk_operation}, 3);
        chk("t5_busy_lo", {31'd0, busy}, 0);

        // Mid-layer reset after 2 of 6 bits
        start(16'd6, 2'd2);
        step();
        step();
        chk("t6_pre_pkv", {31'd0, bus.pk_valid}, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_pkv",  {31'd0, bus.pk_valid}, 0);
        chk("t6_rst_busy", {31'd0, busy}, 0);
        chk("t6_rst_op",   {30'd0, bus.pk_operation}, 0);
        chk("t6_rst_rdy",  {28'd0, bus.ch_ready}, 0);
        step();
        chk("t6_rst_fin",  {31'd0, bus.pk_layer_finish}, 0);
        rst_n = 1'b1;
        step();
        start(16'd2, 2'd1);
        run_count(10, -1, nb, nf, no);
        chk("t6_bits", nb, 2);
        chk("t6_fins", nf, 1);
        chk("t6_ovl", no, 0);
        bus.ch_valid = '0;

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
